// File: rtl/bus_burst_responder.sv
// bus_burst_responder: 512-word burst slave with byte-lane writes and stallable synchronous reads.
// Optional feature macro RESPONDER_BUSY_INJECT_EN: stall write data one cycle after every 4th accepted beat.
module bus_burst_responder #(
    parameter logic [31:0] BASE_ADDRESS = 32'h00F00000,
    parameter int          MEM_WORDS    = 512
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        begin_transactionIN,
    input  logic [31:0] address_dataIN,
    input  logic [3:0]  byte_enableIN,
    input  logic [7:0]  burst_sizeIN,
    input  logic        read_n_writeIN,
    input  logic        data_validIN,
    input  logic        end_transactionIN,
    input  logic        busyIN,
    output logic [31:0] address_dataOUT,
    output logic        data_validOUT,
    output logic        end_transactionOUT,
    output logic        busyOUT,
    output logic        bus_errorOUT,
    output logic [2:0]  s_resp_cur_state
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        READ     = 3'd2,
        READ_END = 3'd3,
        ERROR    = 3'd4
    } state_t;

    state_t      state, nextState;
    logic [31:0] memory [MEM_WORDS];
    logic [31:0] memQ;
    logic [8:0]  wordPtr, readAddr, beatsLeft;
    logic [3:0]  byteEnable;
    logic        outValid;
    logic [29:0] wordOffset;
    logic [30:0] lastWord;
    logic        rangeError, writeBeat, readBeat, lastRead;

    always_comb begin
        wordOffset = 30'((address_dataIN - BASE_ADDRESS) >> 2);
        lastWord   = {1'b0, wordOffset} + 31'(burst_sizeIN);
        rangeError = (address_dataIN < BASE_ADDRESS) || (lastWord > 31'(MEM_WORDS - 1));
        writeBeat  = (state == WRITE) && data_validIN && !busyOUT && (beatsLeft != 9'd0);
        readBeat   = (state == READ) && outValid && !busyIN;
        lastRead   = (beatsLeft == 9'd1);
        // Look one word ahead on a consumed beat so the next beat is ready at the following edge.
        readAddr   = readBeat ? wordPtr + 9'd1 : wordPtr;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (begin_transactionIN)
                    nextState = rangeError ? ERROR : (read_n_writeIN ? READ : WRITE);
            end
            WRITE:    if (end_transactionIN) nextState = IDLE;
            READ:     if (readBeat && lastRead) nextState = READ_END;
            READ_END: nextState = IDLE;
            ERROR:    nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wordPtr    <= '0;
            beatsLeft  <= '0;
            byteEnable <= '0;
            outValid   <= 1'b0;
        end else begin
            outValid <= (state == READ) && !(readBeat && lastRead);
            if (state == IDLE && begin_transactionIN) begin
                wordPtr    <= wordOffset[8:0];
                beatsLeft  <= {1'b0, burst_sizeIN} + 9'd1;
                byteEnable <= byte_enableIN;
            end else if (writeBeat || readBeat) begin
                wordPtr   <= wordPtr + 9'd1;
                beatsLeft <= beatsLeft - 9'd1;
            end
        end
    end

    // Storage survives reset; only the read register feeds the output mux.
    always_ff @(posedge clock) begin
        if (writeBeat) begin
            for (int b = 0; b < 4; b++)
                if (byteEnable[b]) memory[wordPtr][8*b +: 8] <= address_dataIN[8*b +: 8];
        end
        memQ <= memory[readAddr];
    end

`ifdef RESPONDER_BUSY_INJECT_EN
    logic [1:0] beatCount;
    logic       busyReg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beatCount <= '0;
            busyReg   <= 1'b0;
        end else begin
            if (state == IDLE && begin_transactionIN) beatCount <= '0;
            else if (writeBeat)                       beatCount <= beatCount + 2'd1;
            busyReg <= writeBeat && (beatCount == 2'd3);
        end
    end

    assign busyOUT = busyReg;
`else
    assign busyOUT = 1'b0;
`endif

    assign address_dataOUT    = outValid ? memQ : 32'd0;
    assign data_validOUT      = outValid;
    assign end_transactionOUT = (state == READ_END);
    assign bus_errorOUT       = (state == ERROR);
    assign s_resp_cur_state   = state;
endmodule

// File: tb/tb_bus_burst_responder.sv
// tb_bus_burst_responder: directed and randomized bursts checked every cycle against a
// transaction-level model (word array + expected-read queue) of the responder.
module tb_bus_burst_responder;
    localparam logic [31:0] BASE = 32'h00F00000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        begin_transactionIN, read_n_writeIN, data_validIN, end_transactionIN, busyIN;
    logic [31:0] address_dataIN;
    logic [3:0]  byte_enableIN;
    logic [7:0]  burst_sizeIN;
    logic [31:0] address_dataOUT;
    logic        data_validOUT, end_transactionOUT, busyOUT, bus_errorOUT;
    logic [2:0]  s_resp_cur_state;

    always #5 clock = ~clock;

    bus_burst_responder #(.BASE_ADDRESS(BASE)) dut (
        .clock(clock), .reset(reset),
        .begin_transactionIN(begin_transactionIN), .address_dataIN(address_dataIN),
        .byte_enableIN(byte_enableIN), .burst_sizeIN(burst_sizeIN),
        .read_n_writeIN(read_n_writeIN), .data_validIN(data_validIN),
        .end_transactionIN(end_transactionIN), .busyIN(busyIN),
        .address_dataOUT(address_dataOUT), .data_validOUT(data_validOUT),
        .end_transactionOUT(end_transactionOUT), .busyOUT(busyOUT),
        .bus_errorOUT(bus_errorOUT), .s_resp_cur_state(s_resp_cur_state)
    );

    int total = 0, bad = 0, timeouts = 0;

    // Model state, owned by the compare process.
    logic [31:0] mdlMem [512];
    logic [31:0] rdQ[$];
    int          expState = 0, nState, wPtr, wLeft, wCnt, idx, litIdx = 0;
    bit          expValid = 0, expBusy = 0, nValid, nBusy, acc;
    logic [3:0]  wBe;

    // Hand-written expected read words, written only by the stimulus.
    logic [31:0] litQ[$];

    function automatic bit inRange(input logic [31:0] a, input logic [7:0] bs);
        logic [31:0] off;
        if (a < BASE) return 1'b0;
        off = (a - BASE) >> 2;
        return (off + 32'(bs)) <= 32'd511;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            chk("rst_state", 32'(s_resp_cur_state), 32'd0);
            chk("rst_data",  address_dataOUT, 32'd0);
            chk("rst_valid", 32'(data_validOUT), 32'd0);
            chk("rst_end",   32'(end_transactionOUT), 32'd0);
            chk("rst_busy",  32'(busyOUT), 32'd0);
            chk("rst_err",   32'(bus_errorOUT), 32'd0);
            expState = 0; expValid = 0; expBusy = 0; wLeft = 0;
            rdQ.delete();
            litIdx = litQ.size();
        end else begin
            chk("state",     32'(s_resp_cur_state), 32'(expState));
            chk("bus_error", 32'(bus_errorOUT), 32'(expState == 4));
            chk("end_txn",   32'(end_transactionOUT), 32'(expState == 3));
            chk("busy",      32'(busyOUT), 32'(expBusy));
            chk("rd_valid",  32'(data_validOUT), 32'(expValid));
            chk("rd_data",   address_dataOUT, (expValid && rdQ.size() > 0) ? rdQ[0] : 32'd0);
            chk("timeouts",  32'(timeouts), 32'd0);

            nState = expState; nValid = expValid; nBusy = 1'b0;
            case (expState)
                0: if (begin_transactionIN) begin
                    if (!inRange(address_dataIN, burst_sizeIN)) nState = 4;
                    else begin
                        idx = int'((address_dataIN - BASE) >> 2);
                        if (read_n_writeIN) begin
                            rdQ.delete();
                            for (int i = 0; i <= int'(burst_sizeIN); i++)
                                rdQ.push_back(mdlMem[9'(idx + i)]);
                            nState = 2;
                        end else begin
                            wPtr = idx; wLeft = int'(burst_sizeIN) + 1; wBe = byte_enableIN; wCnt = 0;
                            nState = 1;
                        end
                    end
                end
                1: begin
                    acc = data_validIN && !expBusy && wLeft > 0;
                    if (acc) begin
                        for (int b = 0; b < 4; b++)
                            if (wBe[b]) mdlMem[9'(wPtr)][8*b +: 8] = address_dataIN[8*b +: 8];
                        wPtr++; wLeft--; wCnt++;
`ifdef RESPONDER_BUSY_INJECT_EN
                        nBusy = (wCnt % 4 == 0);
`endif
                    end
                    if (end_transactionIN) nState = 0;
                end
                2: begin
                    if (!expValid) nValid = 1'b1;
                    else if (!busyIN) begin
                        if (litIdx < litQ.size()) begin
                            chk("literal", address_dataOUT, litQ[litIdx]);
                            litIdx++;
                        end
                        void'(rdQ.pop_front());
                        if (rdQ.size() == 0) begin nValid = 1'b0; nState = 3; end
                    end
                end
                default: nState = 0;
            endcase
            expState = nState; expValid = nValid; expBusy = nBusy;
        end
    end

    task automatic beginTxn(input logic [31:0] a, input logic [7:0] bs, input logic [3:0] be, input bit rd);
        begin_transactionIN = 1'b1; address_dataIN = a; burst_sizeIN = bs;
        byte_enableIN = be; read_n_writeIN = rd;
        @(posedge clock); #1;
        begin_transactionIN = 1'b0; address_dataIN = 32'd0;
    endtask

    task automatic doWrite(input logic [31:0] a, input logic [7:0] bs, input logic [3:0] be,
                           input int nSend, input bit seq, input logic [31:0] seqBase, input bit gaps);
        int guard;
        bit accepted;
        beginTxn(a, bs, be, 1'b0);
        for (int i = 0; i < nSend; i++) begin
            while (gaps && $urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
            data_validIN = 1'b1;
            address_dataIN = seq ? seqBase + 32'(i) : $urandom();
            accepted = 1'b0; guard = 0;
            while (!accepted && guard < 20) begin
                accepted = !busyOUT;
                @(posedge clock); #1;
                guard++;
            end
            if (!accepted) timeouts++;
            data_validIN = 1'b0; address_dataIN = 32'd0;
        end
        end_transactionIN = 1'b1;
        @(posedge clock); #1;
        end_transactionIN = 1'b0;
    endtask

    // mode 0: random busyIN, 1: never busy, 2: hold beat 2 for 3 cycles, 3: reset during beat 5
    task automatic doRead(input logic [31:0] a, input logic [7:0] bs, input int mode);
        int guard = 0, beat = 0, held = 0;
        bit done = 1'b0, v;
        beginTxn(a, bs, 4'hF, 1'b1);
        while (!done && guard < 3000) begin
            v = data_validOUT;
            case (mode)
                0:       busyIN = ($urandom_range(0, 3) == 0);
                2:       busyIN = v && beat == 1 && held < 3;
                default: busyIN = 1'b0;
            endcase
            if (busyIN) held++;
            if (mode == 3 && v && beat == 4) begin
                #2 reset = 1'b1;
                @(posedge clock); #1 reset = 1'b0;
                done = 1'b1;
            end else begin
                @(posedge clock); #1;
                guard++;
                if (v && !busyIN) beat++;
                if (end_transactionOUT) done = 1'b1;
            end
        end
        busyIN = 1'b0;
        if (!done) timeouts++;
        else if (mode != 3) begin @(posedge clock); #1; end
    endtask

    task automatic errTxn(input logic [31:0] a, input logic [7:0] bs);
        beginTxn(a, bs, 4'hF, 1'($urandom_range(0, 1)));
        @(posedge clock); #1;
    endtask

    initial begin
        logic [31:0] ra;
        logic [7:0]  rbs;
        for (int i = 0; i < 512; i++) mdlMem[i] = 32'd0;
        begin_transactionIN = 1'b0; data_validIN = 1'b0; end_transactionIN = 1'b0; busyIN = 1'b0;
        address_dataIN = 32'd0; byte_enableIN = 4'd0; burst_sizeIN = 8'd0; read_n_writeIN = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Fill all storage so every later read has a defined expectation.
        doWrite(BASE,         8'd255, 4'hF, 256, 1'b0, 32'd0, 1'b0);
        doWrite(BASE + 1024,  8'd255, 4'hF, 256, 1'b0, 32'd0, 1'b0);

        doWrite(BASE, 8'd9, 4'hF, 10, 1'b1, 32'hA0000000, 1'b0);
        for (int i = 0; i < 10; i++) litQ.push_back(32'hA0000000 + 32'(i));
        doRead(BASE, 8'd9, 1);

        doWrite(BASE + 16, 8'd0, 4'hF,    1, 1'b1, 32'hFFFFFFFF, 1'b1);
        doWrite(BASE + 16, 8'd0, 4'b0011, 1, 1'b1, 32'h00001234, 1'b1);
        litQ.push_back(32'hFFFF1234);
        doRead(BASE + 16, 8'd0, 1);

        doWrite(BASE + 32, 8'd3, 4'hF, 4, 1'b1, 32'hC0DE0000, 1'b0);
        for (int i = 0; i < 4; i++) litQ.push_back(32'hC0DE0000 + 32'(i));
        doRead(BASE + 32, 8'd3, 2);

        doWrite(BASE + 32'h7F8, 8'd1, 4'hF, 2, 1'b1, 32'h5EED0000, 1'b0);
        errTxn(BASE + 32'h7FC, 8'd1);
        errTxn(32'hAABBCCDD, 8'd0);
        errTxn(BASE - 32'd4, 8'd0);
        litQ.push_back(32'h5EED0000); litQ.push_back(32'h5EED0001);
        doRead(BASE + 32'h7F8, 8'd1, 1);

        // Early end after 3 of 8 beats, then 5 beats offered to a 2-beat burst.
        doWrite(BASE + 64, 8'd7, 4'hF, 3, 1'b1, 32'hB0000000, 1'b1);
        doWrite(BASE + 96, 8'd1, 4'hF, 5, 1'b1, 32'hD0000000, 1'b1);
        for (int i = 0; i < 3; i++) litQ.push_back(32'hB0000000 + 32'(i));
        doRead(BASE + 64, 8'd2, 0);
        litQ.push_back(32'hD0000000); litQ.push_back(32'hD0000001);
        doRead(BASE + 96, 8'd1, 0);
        doRead(BASE + 64, 8'd15, 0);

        doRead(BASE + 32'h100, 8'd19, 3);
        for (int i = 0; i < 4; i++) litQ.push_back(32'hC0DE0000 + 32'(i));
        doRead(BASE + 32, 8'd3, 0);

        repeat (40) begin
            rbs = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0:       ra = $urandom();
                1:       ra = BASE - 32'($urandom_range(1, 64));
                default: ra = BASE + 32'($urandom_range(0, 2047));
            endcase
            if (!inRange(ra, rbs))          errTxn(ra, rbs);
            else if ($urandom_range(0, 1) == 1) doRead(ra, rbs, 0);
            else doWrite(ra, rbs, 4'($urandom_range(0, 15)), int'($urandom_range(1, 32'(rbs) + 3)),
                         1'b0, 32'd0, 1'b1);
        end

        repeat (3) @(posedge clock);
        #1 $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_burst_responder.md
BUS_BURST_RESPONDER -- requirements
Module: bus_burst_responder

Interface
REQ-001 Parameter BASE_ADDRESS, default 32'h00F00000, byte address of the first word of the responder window.
REQ-002 Parameter MEM_WORDS, fixed at 512: 32-bit words of internal storage, window BASE_ADDRESS..BASE_ADDRESS+0x7FF.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 begin_transactionIN  input  1  master starts a transaction this cycle.
REQ-006 address_dataIN  input  32  start byte address in the begin cycle, write data in data beats.
REQ-007 byte_enableIN  input  4  byte lanes for the writes of the transaction; sampled in the begin cycle.
REQ-008 burst_sizeIN  input  8  number of beats minus 1; sampled in the begin cycle.
REQ-009 read_n_writeIN  input  1  1 = read, 0 = write; sampled in the begin cycle.
REQ-010 data_validIN  input  1  write data on address_dataIN is valid.
REQ-011 end_transactionIN  input  1  master closes a write transaction.
REQ-012 busyIN  input  1  master stalls read data.
REQ-013 address_dataOUT  output  32  read data.
REQ-014 data_validOUT  output  1  read data valid.
REQ-015 end_transactionOUT  output  1  responder closes a read transaction.
REQ-016 busyOUT  output  1  responder stalls write data.
REQ-017 bus_errorOUT  output  1  transaction rejected.
REQ-018 s_resp_cur_state  output  3  current FSM state, for debug.

Function
REQ-019 FSM states: IDLE=0, WRITE=1, READ=2, READ_END=3, ERROR=4.
REQ-020 In IDLE, begin_transactionIN latches the address, byte enables, beat count (burst_sizeIN+1) and direction.
REQ-021 In any state other than IDLE, begin_transactionIN is ignored.
REQ-022 Range check: if start address < BASE_ADDRESS, or start word index + burst_sizeIN > 511, the next state is ERROR; otherwise it is WRITE or READ.
REQ-023 ERROR: bus_errorOUT is high for exactly one cycle, there is no storage access, and the next state is IDLE.
REQ-024 Word index is address bits [10:2] relative to BASE_ADDRESS; address bits [1:0] are ignored.
REQ-025 Word index increments by 1 per accepted beat and never wraps, because wrap-around is excluded by REQ-022.
REQ-026 WRITE: a beat is accepted in a cycle where data_validIN=1 and busyOUT=0.
REQ-027 Each accepted write beat updates only the byte lanes enabled in the latched byte enables.
REQ-028 WRITE: beats beyond the latched beat count are discarded.
REQ-029 WRITE: end_transactionIN moves the FSM to IDLE at the next edge, including mid-burst; beats already accepted stay written.
REQ-030 READ: storage read is synchronous; the first data_validOUT appears 2 cycles after the begin cycle.
REQ-031 READ: a beat is consumed at an edge where data_validOUT=1 and busyIN=0.
REQ-032 READ: while busyIN=1, address_dataOUT and data_validOUT hold their values.
REQ-033 READ: after the last beat is consumed, data_validOUT drops, the FSM enters READ_END, end_transactionOUT is high for one cycle, and the FSM returns to IDLE.
REQ-034 burst_sizeIN=0 gives a single-beat transaction; burst_sizeIN=255 gives 256 beats.
REQ-035 address_dataOUT is 0 whenever data_validOUT=0.

Reset
REQ-036 Reset asserted at any time, including mid-burst, forces IDLE immediately and drives all outputs to 0.
REQ-037 Storage contents are not cleared by reset.
REQ-038 After reset deasserts, the first accepted begin_transactionIN is the one at the first rising edge.

Configuration
REQ-039 With macro RESPONDER_BUSY_INJECT_EN defined, busyOUT is high for the one cycle following every 4th accepted write beat, and data offered during that cycle is not accepted.
REQ-040 Without RESPONDER_BUSY_INJECT_EN, busyOUT is constant 0.

Verification
REQ-041 Write 10 beats at 32'h00F00000, byte enables 4'b1111, data A0000000+i, then a 10-beat read of the same range -> read data A0000000..A0000009, end_transactionOUT one cycle after the last beat.
REQ-042 Write one beat at 32'h00F00010 of 32'hFFFFFFFF, then one beat with byte enables 4'b0011 and data 32'h00001234, then read -> 32'hFFFF1234.
REQ-043 Read of 4 beats with busyIN high for 3 cycles on beat 2 -> beat 2 held for 3 cycles, 4 distinct beats delivered in order.
REQ-044 Begin at 32'h00F007FC with burst_sizeIN=1 or at 32'hAABBCCDD -> bus_errorOUT pulse one cycle later, storage unchanged, IDLE.
REQ-045 Reset asserted during beat 5 of a 20-beat read -> all outputs 0 immediately, state 0, next begin accepted normally.
REQ-046 With RESPONDER_BUSY_INJECT_EN, continuous 8-beat write -> busyOUT after beats 4 and 8, all 8 words stored correctly when the master holds data.
